// File: rtl/des_dkey_sched.sv
// des_dkey_sched: iterative DES key scheduler, decryption order (K16 first, K1 last).
//
// A 64-bit key is accepted on a valid/ready handshake and loaded through PC-1 into the
// 28-bit C/D halves. In RUN, the block presents one PC-2 subkey per cycle. After each
// accepted subkey it rotates C/D right, which walks the schedule backwards from K16 to K1.
//
// Ports:
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   flush         synchronous abort back to IDLE (round cleared, C/D untouched)
//   key_in        DES key, key_in[63] = FIPS bit 1; parity bits ignored
//   key_valid     key_in valid
//   key_ready     scheduler idle and able to take a key
//   subkey        PC-2 of current C/D, subkey[47] = PC-2 bit 1
//   subkey_valid  subkey valid (RUN)
//   subkey_ready  consumer takes subkey this cycle
//   round         index of presented subkey (0 -> K16 ... 15 -> K1)
//   last          subkey_valid and round == 15
//
// Optional feature, macro DES_DKEY_ENC_MODE_EN:
//   adds input 'decrypt'. It is sampled on key acceptance into a mode register (reset 1).
//   With decrypt = 0 the stream is in encryption order (K1 first), built with left rotations.

module des_dkey_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [63:0] key_in,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round,
  output logic        last
`ifdef DES_DKEY_ENC_MODE_EN
  ,
  input  logic        decrypt
`endif
);

  // FIPS 46-3 tables, entries are 1-based FIPS bit numbers (bit 1 = MSB).
  localparam int unsigned Pc1Tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned Pc2Tab [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // PC-1: 64-bit key -> 56-bit {C,D}, output bit 1 lands at r[55].
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - Pc1Tab[i])];
    end
    return r;
  endfunction

  // PC-2: 56-bit {C,D} -> 48-bit subkey, output bit 1 lands at r[47].
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[6'(47 - i)] = cd[6'(56 - Pc2Tab[i])];
    end
    return r;
  endfunction

  // Right rotate within a half: FIPS bit 28 (LSB) wraps to bit 1 (MSB).
  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic single);
    return single ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic single);
    return single ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic [55:0] cd_load;
  logic        single_step;

  // Parity bits never feed PC-1; keep them visibly sunk.
  logic unused_parity;
  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

  assign cd_load = pc1(key_in);

  // Decrypt steps use amt(round+1), encrypt steps use shift(round+2). Both single-bit
  // positions fall on round 0, 7 and 14, so one decode serves both directions.
  assign single_step = (round_q == 4'd0) || (round_q == 4'd7) || (round_q == 4'd14);

`ifdef DES_DKEY_ENC_MODE_EN
  logic mode_q, mode_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b1;
    end else begin
      mode_q <= mode_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
`ifdef DES_DKEY_ENC_MODE_EN
    mode_d  = mode_q;
`endif

    if (flush) begin
      // Any handshake this cycle is dropped; C/D keep their contents.
      state_d = StIdle;
      round_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (key_valid) begin
            c_d     = cd_load[55:28];
            d_d     = cd_load[27:0];
            round_d = '0;
            state_d = StRun;
`ifdef DES_DKEY_ENC_MODE_EN
            mode_d  = decrypt;
            if (!decrypt) begin
              // Encryption starts at K1, i.e. one left shift past PC-1.
              c_d = rotl28(cd_load[55:28], 1'b1);
              d_d = rotl28(cd_load[27:0], 1'b1);
            end
`endif
          end
        end

        StRun: begin
          if (subkey_ready) begin
            if (round_q == 4'd15) begin
              state_d = StIdle;
            end else begin
              round_d = round_q + 4'd1;
`ifdef DES_DKEY_ENC_MODE_EN
              if (mode_q) begin
                c_d = rotr28(c_q, single_step);
                d_d = rotr28(d_q, single_step);
              end else begin
                c_d = rotl28(c_q, single_step);
                d_d = rotl28(d_q, single_step);
              end
`else
              c_d = rotr28(c_q, single_step);
              d_d = rotr28(d_q, single_step);
`endif
            end
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Outputs come from registered state only; subkey is stable while stalled.
  assign key_ready    = (state_q == StIdle);
  assign subkey_valid = (state_q == StRun);
  assign subkey       = pc2({c_q, d_q});
  assign round        = round_q;
  assign last         = (state_q == StRun) && (round_q == 4'd15);

endmodule

// File: tb/tb_des_dkey_sched.sv
// Bench for des_dkey_sched. The reference computes the standard DES key schedule in
// encryption order (left shifts per round) and the expected decrypt stream is its reverse.
module tb_des_dkey_sched;

  localparam logic [63:0] RefKey = 64'h133457799BBCDFF1;

  localparam int unsigned Pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int unsigned Pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int unsigned Shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] key_in = '0;
  logic        key_valid = 1'b0;
  logic        key_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic        subkey_ready = 1'b0;
  logic [3:0]  round;
  logic        last;
`ifdef DES_DKEY_ENC_MODE_EN
  logic        decrypt = 1'b1;
`endif

  int tests = 0;
  int fails = 0;

  // ref_ks[i] holds K(i+1), encryption order.
  logic [47:0] ref_ks [16];
  logic [47:0] ref_a  [16];

  des_dkey_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .key_in       (key_in),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round        (round),
    .last         (last)
`ifdef DES_DKEY_ENC_MODE_EN
    ,
    .decrypt      (decrypt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [27:0] rol(input logic [27:0] x, input int unsigned n);
    logic [27:0] y;
    y = x;
    for (int i = 0; i < int'(n); i++) y = {y[26:0], y[27]};
    return y;
  endfunction

  // Textbook DES key schedule from FIPS bit numbers.
  task automatic compute_ref(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] k;
    for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - Pc1[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      c = rol(c, Shifts[r]);
      d = rol(d, Shifts[r]);
      cd = {c, d};
      for (int j = 0; j < 48; j++) k[47 - j] = cd[56 - Pc2[j]];
      ref_ks[r] = k;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
  task automatic send_key(input logic [63:0] k);
    key_in    = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  initial begin
    int idx;
    int cyc;

    // ---- reset state
    repeat (2) @(negedge clk);
    check("rst key_ready", 64'(key_ready), 64'd1);
    check("rst subkey_valid", 64'(subkey_valid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle subkey", 64'(subkey), 64'd0);
    check("idle round", 64'(round), 64'd0);
    check("idle last", 64'(last), 64'd0);

    // ---- reference vector, full throughput
    compute_ref(RefKey);
    subkey_ready = 1'b1;
    send_key(RefKey);
    for (int r = 0; r < 16; r++) begin
      check("ref valid", 64'(subkey_valid), 64'd1);
      check("ref key_ready", 64'(key_ready), 64'd0);
      check("ref round", 64'(round), 64'(r));
      check("ref subkey", 64'(subkey), 64'(ref_ks[15 - r]));
      check("ref last", 64'(last), 64'(r == 15));
      if (r == 0)  check("ref K16 vector", 64'(subkey), 64'h0000CB3D8B0E17F5);
      if (r == 1)  check("ref K15 vector", 64'(subkey), 64'h0000BF918D3D3F0A);
      if (r == 15) check("ref K1 vector", 64'(subkey), 64'h00001B02EFFC7072);
      @(negedge clk);
    end
    check("ref done key_ready", 64'(key_ready), 64'd1);
    check("ref done valid", 64'(subkey_valid), 64'd0);

    // ---- random backpressure, random keys
    for (int n = 0; n < 4; n++) begin
      logic [63:0] k;
      k = (n == 0) ? RefKey : {$urandom(), $urandom()};
      compute_ref(k);
      send_key(k);
      idx = 0;
      cyc = 0;
      while (idx < 16 && cyc < 200) begin
        cyc++;
        check("bp valid", 64'(subkey_valid), 64'd1);
        check("bp round", 64'(round), 64'(idx));
        check("bp subkey", 64'(subkey), 64'(ref_ks[15 - idx]));
        check("bp last", 64'(last), 64'(idx == 15));
        subkey_ready = 1'($urandom_range(0, 1));
        if (subkey_ready) idx++;
        @(negedge clk);
      end
      check("bp completed", 64'(idx), 64'd16);
      check("bp idle", 64'(key_ready), 64'd1);
    end

    // ---- flush at round 5
    subkey_ready = 1'b1;
    compute_ref(RefKey);
    send_key(RefKey);
    repeat (5) @(negedge clk);
    check("flush pre round", 64'(round), 64'd5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush valid", 64'(subkey_valid), 64'd0);
    check("flush key_ready", 64'(key_ready), 64'd1);
    check("flush round", 64'(round), 64'd0);
    // Flush in IDLE drops an offered key.
    key_in    = RefKey;
    key_valid = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    key_valid = 1'b0;
    check("flush drops key", 64'(subkey_valid), 64'd0);
    send_key(RefKey);
    check("flush restart", 64'(subkey), 64'h0000CB3D8B0E17F5);
    check("flush restart round", 64'(round), 64'd0);
    repeat (16) @(negedge clk);
    check("flush run end", 64'(key_ready), 64'd1);

    // ---- asynchronous reset at round 9
    send_key(RefKey);
    repeat (9) @(negedge clk);
    check("rst pre round", 64'(round), 64'd9);
    #2 rst_n = 1'b0;
    #1;
    check("async rst key_ready", 64'(key_ready), 64'd1);
    check("async rst valid", 64'(subkey_valid), 64'd0);
    check("async rst subkey", 64'(subkey), 64'd0);
    check("async rst last", 64'(last), 64'd0);
    check("async rst round", 64'(round), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst idle", 64'(key_ready), 64'd1);

    // ---- key_valid held through RUN; key_in changes mid-stream
    compute_ref({$urandom(), $urandom()});
    ref_a = ref_ks;
    key_in    = 64'h0;
    for (int i = 0; i < 56; i++) key_in[64 - Pc1[i]] = 1'b0;
    compute_ref(64'hFEDCBA9876543210 ^ {$urandom(), $urandom()});
    begin
      logic [63:0] kb;
      kb = key_in;
    end
    begin
      logic [63:0] ka, kb;
      ka = {$urandom(), $urandom()};
      kb = {$urandom(), $urandom()};
      compute_ref(ka);
      ref_a = ref_ks;
      compute_ref(kb);
      key_in    = ka;
      key_valid = 1'b1;
      @(negedge clk);
      for (int r = 0; r < 16; r++) begin
        check("gate round", 64'(round), 64'(r));
        check("gate subkey", 64'(subkey), 64'(ref_a[15 - r]));
        check("gate key_ready", 64'(key_ready), 64'd0);
        if (r == 3) key_in = kb;
        @(negedge clk);
      end
      check("gate ready again", 64'(key_ready), 64'd1);
      @(negedge clk);
      key_valid = 1'b0;
      check("gate second key", 64'(subkey), 64'(ref_ks[15]));
      check("gate second round", 64'(round), 64'd0);
      repeat (16) @(negedge clk);
      check("gate second end", 64'(key_ready), 64'd1);
    end

`ifdef DES_DKEY_ENC_MODE_EN
    // ---- encryption order
    compute_ref(RefKey);
    decrypt = 1'b0;
    send_key(RefKey);
    decrypt = 1'b1;
    for (int r = 0; r < 16; r++) begin
      check("enc round", 64'(round), 64'(r));
      check("enc subkey", 64'(subkey), 64'(ref_ks[r]));
      if (r == 0)  check("enc K1 vector", 64'(subkey), 64'h00001B02EFFC7072);
      if (r == 15) check("enc K16 vector", 64'(subkey), 64'h0000CB3D8B0E17F5);
      @(negedge clk);
    end
    check("enc done", 64'(key_ready), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/des_dkey_sched.md
# des_dkey_sched

- Iterative DES key scheduler that produces the 16 round subkeys in decryption order, K16 first and K1 last.
- Accepts one 64-bit key through a valid/ready handshake, applies PC-1, then streams one PC-2 subkey per handshake. It rotates the C/D halves right between subkeys.
- Sits beside the round datapath (E-expansion, S-boxes, P permutation) and is its key supplier when running in decrypt mode.

## Interface
Parameters: none.

- clk  input  1  — single clock; all registers on rising edge
- rst_n  input  1  — reset, asynchronous, active-low
- flush  input  1  — synchronous abort; return to IDLE
- key_in  input  64  — DES key; key_in[63] = FIPS bit 1; parity bits (FIPS bits 8,16,…,64) ignored
- key_valid  input  1  — key_in valid
- key_ready  output  1  — scheduler can accept a key
- subkey  output  48  — current round subkey; subkey[47] = PC-2 output bit 1
- subkey_valid  output  1  — subkey valid
- subkey_ready  input  1  — consumer takes subkey this cycle
- round  output  4  — index of subkey being presented: 0 → K16 … 15 → K1
- last  output  1  — high when subkey_valid and round == 15

## Operation
- **Tables:** PC-1 and PC-2 are the FIPS 46-3 tables, bit 1 = MSB.
- **State:** registers C[27:0], D[27:0], round[3:0], and a 2-state FSM (IDLE, RUN).
- **IDLE:**
  - key_ready = 1 and subkey_valid = 0.
  - On key_valid & key_ready: {C,D} ← PC1(key_in), round ← 0, go to RUN.
- **RUN:**
  - key_ready = 0 and subkey_valid = 1.
  - subkey = PC2(C,D), combinational from the registers and therefore stable while stalled.
- **Handshake in RUN (subkey_valid & subkey_ready):**
  - If round == 15: go to IDLE; C, D, and round hold.
  - Otherwise: round ← round+1, and C, D each rotate right by amt(round+1).
  - amt(j) = 1 for j ∈ {1, 8, 15}, else 2.
- **Rotation rule:** rotation is within each 28-bit half, MSB side is FIPS bit 1; a right rotate moves bit 28 into bit 1. Total rotation across the stream is 27 per half, so K1 = PC2 of (C0,D0 rotated left by 1).
- **Stall:** subkey_valid & !subkey_ready → all state holds and subkey is unchanged.
- **flush:** highest priority after reset. Next state is IDLE and round ← 0. Any in-flight handshake that cycle (key or subkey) is discarded, and C/D are not updated.
- **Key arrival in RUN:** ignored, because key_ready = 0. The upstream holds key_valid.
- **Reset values:**
  - FSM = IDLE, C = D = 0, round = 0.
  - Outputs: key_ready = 1, subkey_valid = 0, subkey = 0, last = 0.

## Timing
- **Key to first subkey:** key accepted at edge N; K16 valid after edge N (available cycle N+1). One cycle of latency.
- **Throughput:** one subkey per cycle with subkey_ready held high. 16 subkeys occupy cycles N+1…N+16.
- **Next key:** key_ready rises in cycle N+17, so a new key can be accepted at the earliest in that cycle. This gives 17 cycles per key minimum.
- **Handshake rules:** key_ready and subkey_valid depend only on registered state, never combinationally on key_valid or subkey_ready. A consumer may assert subkey_ready without waiting for subkey_valid.
- **Reset mid-stream:** asynchronous assertion of rst_n clears everything immediately, and the subkey stream is abandoned. Deassertion is synchronised externally.

## Configuration
- **Macro:** DES_DKEY_ENC_MODE_EN.
- **With the macro defined:**
  - Extra port: decrypt, input, 1 bit, sampled only on key acceptance and stored in a mode register (reset 1).
  - decrypt = 1: behaviour as above.
  - decrypt = 0: encryption order, K1 first, round 0 → K1. At key accept, {C,D} ← PC1(key_in) rotated left by 1. Each step rotates left by shift(round+2), where shift = 1 for rounds 1, 2, 9, 16 and 2 otherwise.
- **Without the macro:** the port and mode register are absent, and the block is decrypt-only.

## Test plan
- **Reference vector:** after reset, key 0x133457799BBCDFF1, subkey_ready = 1.
  - Cycle 1: subkey 0xCB3D8B0E17F5, round 0.
  - Next cycle: 0xBF918D3D3F0A.
  - Cycle 16: 0x1B02EFFC7072 with last = 1.
  - Cycle 17: key_ready = 1.
- **Backpressure:** same key, subkey_ready toggled with a random 50% pattern.
  - The same 16-subkey sequence is produced in order.
  - subkey holds stable across every stall.
- **Flush:** flush asserted at round 5 together with subkey_ready.
  - Next cycle: IDLE, subkey_valid = 0, key_ready = 1.
  - Re-accepting the key restarts at 0xCB3D8B0E17F5.
- **Reset and key gating:**
  - rst_n pulsed low at round 9: all outputs reach their reset values immediately.
  - key_valid held high throughout RUN: no second key is accepted until key_ready = 1.
- **Encrypt mode (DES_DKEY_ENC_MODE_EN builds only):** decrypt = 0 with key 0x133457799BBCDFF1.
  - First subkey 0x1B02EFFC7072, last subkey 0xCB3D8B0E17F5.
  - All 16 subkeys match the reverse of the decrypt-mode stream.
